// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - CPU data-bus bundle between the address decoder and the timer
interface mmio_timer_if;
  logic        WEtimer;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        irq;

  modport master (
    output WEtimer,
    output DataAdr,
    output WriteData,
    input  ReadData,
    input  irq
  );

  modport slave (
    input  WEtimer,
    input  DataAdr,
    input  WriteData,
    output ReadData,
    output irq
  );
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - prescaled one-shot/auto-reload down-counter on the data bus; TIMER_CAPTURE_EN adds cap_in and CAPTURE at +10
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h804,
  parameter int          WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef TIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  mmio_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_load;
  logic [WIDTH-1:0] r_count;
  logic [7:0]       r_prescale;
  logic [7:0]       r_pre_cnt;
  logic             r_auto;
  logic             r_irq_en;
  logic             r_expired;

  logic             w_hit_ctrl;
  logic             w_hit_load;
  logic             w_hit_count;
  logic             w_hit_status;
  logic             w_wr_ctrl;
  logic             w_wr_load;
  logic             w_wr_count;
  logic             w_wr_status;
  logic             w_en_req;
  logic             w_en;
  logic             w_tick;
  logic             w_count_zero;
  logic             w_start;
  logic             w_run_step;
  logic             w_cnt_step;
  logic             w_expire;
  logic [31:0]      w_rdata;

  // Exact word-address decode; anything else on the bus is not ours
  assign w_hit_ctrl   = (bus.DataAdr == BASE_ADDR);
  assign w_hit_load   = (bus.DataAdr == BASE_ADDR + 32'h4);
  assign w_hit_count  = (bus.DataAdr == BASE_ADDR + 32'h8);
  assign w_hit_status = (bus.DataAdr == BASE_ADDR + 32'hC);

  assign w_wr_ctrl    = bus.WEtimer & w_hit_ctrl;
  assign w_wr_load    = bus.WEtimer & w_hit_load;
  assign w_wr_count   = bus.WEtimer & w_hit_count;
  assign w_wr_status  = bus.WEtimer & w_hit_status;

  assign w_en_req     = bus.WriteData[0];
  assign w_en         = (r_state == S_RUN);
  assign w_tick       = (r_pre_cnt == r_prescale);
  assign w_count_zero = (r_count == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the datapath strobes that depend on the current state
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_run_step  = 1'b0;
    w_cnt_step  = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_ctrl && w_en_req) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_wr_ctrl && !w_en_req) begin
          // Stopping freezes both count and prescaler where they are
          w_state_nxt = S_IDLE;
        end else begin
          w_run_step = 1'b1;
          // A software COUNT write in the same cycle overrides the tick
          w_cnt_step = w_tick & ~w_wr_count;
          w_expire   = w_cnt_step & w_count_zero;
          if (w_expire && !r_auto) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (w_wr_ctrl) begin
          w_state_nxt = w_en_req ? S_RUN : S_IDLE;
          w_start     = w_en_req;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration registers; EN itself lives in the state, not here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= 8'h00;
      r_load     <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_auto     <= bus.WriteData[1];
        r_irq_en   <= bus.WriteData[2];
        r_prescale <= bus.WriteData[15:8];
      end
      if (w_wr_load) begin
        r_load <= bus.WriteData[WIDTH-1:0];
      end
    end
  end

  // Counter: start reload, then software write, then tick decrement/reload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= r_load;
    end else if (w_wr_count) begin
      r_count <= bus.WriteData[WIDTH-1:0];
    end else if (w_cnt_step) begin
      if (w_count_zero) begin
        r_count <= r_auto ? r_load : '0;
      end else begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Prescaler advances only while running; wraps to 0 on each tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= 8'h00;
    end else if (w_start) begin
      r_pre_cnt <= 8'h00;
    end else if (w_run_step) begin
      r_pre_cnt <= w_tick ? 8'h00 : r_pre_cnt + 8'h01;
    end
  end

  // Sticky expiry flag; a same-cycle expiry beats a software clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_expired <= 1'b0;
    end else if (w_expire) begin
      r_expired <= 1'b1;
    end else if (w_wr_status && bus.WriteData[0]) begin
      r_expired <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic             r_cap_s1;
  logic             r_cap_s2;
  logic             r_cap_d;
  logic [WIDTH-1:0] r_capture;
  logic             w_cap_edge;
  logic             w_hit_cap;

  assign w_cap_edge = r_cap_s2 & ~r_cap_d;
  assign w_hit_cap  = (bus.DataAdr == BASE_ADDR + 32'h10);

  // Synchronise cap_in, detect its rising edge and snapshot the pre-update count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_s1  <= 1'b0;
      r_cap_s2  <= 1'b0;
      r_cap_d   <= 1'b0;
      r_capture <= '0;
    end else begin
      r_cap_s1 <= cap_in;
      r_cap_s2 <= r_cap_s1;
      r_cap_d  <= r_cap_s2;
      if (w_cap_edge) begin
        r_capture <= r_count;
      end
    end
  end
`endif

  // Combinational read-back mux; unmapped offsets return 0
  always_comb begin
    w_rdata = 32'h0;
    if (w_hit_ctrl) begin
      w_rdata = {16'h0, r_prescale, 5'h00, r_irq_en, r_auto, w_en};
    end else if (w_hit_load) begin
      w_rdata = 32'(r_load);
    end else if (w_hit_count) begin
      w_rdata = 32'(r_count);
    end else if (w_hit_status) begin
      w_rdata = {31'h0, r_expired};
    end
`ifdef TIMER_CAPTURE_EN
    else if (w_hit_cap) begin
      w_rdata = 32'(r_capture);
    end
`endif
  end

  assign bus.ReadData = w_rdata;
  assign bus.irq      = r_expired & r_irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - self-checking bench for mmio_timer with an arithmetic period model
`timescale 1ns/1ps
module tb_mmio_timer;
  localparam logic [31:0] BASE     = 32'h804;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_LOAD   = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;
  localparam logic [31:0] A_CAP    = BASE + 32'h10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  mmio_timer_if bus();

`ifdef TIMER_CAPTURE_EN
  logic cap_in = 1'b0;
`endif

  mmio_timer #(.BASE_ADDR(BASE), .WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef TIMER_CAPTURE_EN
    .cap_in  (cap_in),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.WEtimer   = 1'b1;
    bus.DataAdr   = a;
    bus.WriteData = d;
    @(posedge clk);
    #1;
    bus.WEtimer   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.DataAdr = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rd(A_CTRL, v);   n_total++; if (v !== 32'h0) $display("FAIL rst_ctrl: got %0h expected 0", v); else n_pass++;
    rd(A_LOAD, v);   n_total++; if (v !== 32'h0) $display("FAIL rst_load: got %0h expected 0", v); else n_pass++;
    rd(A_COUNT, v);  n_total++; if (v !== 32'h0) $display("FAIL rst_count: got %0h expected 0", v); else n_pass++;
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL rst_status: got %0h expected 0", v); else n_pass++;
    n_total++; if (bus.irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", bus.irq); else n_pass++;
    // expire once with IRQ_EN so irq is high, then restart at COUNT=5
    wr(A_LOAD, 32'h0);
    wr(A_CTRL, 32'h5);
    step(1);
    n_total++; if (bus.irq !== 1'b1) $display("FAIL pre_rst_irq: got %b expected 1", bus.irq); else n_pass++;
    wr(A_LOAD, 32'h5);
    wr(A_CTRL, 32'h5);
    rd(A_COUNT, v);  n_total++; if (v !== 32'h5) $display("FAIL pre_rst_count: got %0h expected 5", v); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.irq !== 1'b0) $display("FAIL async_rst_irq: got %b expected 0", bus.irq); else n_pass++;
    rd(A_CTRL, v);   n_total++; if (v !== 32'h0) $display("FAIL async_rst_ctrl: got %0h expected 0", v); else n_pass++;
    rd(A_LOAD, v);   n_total++; if (v !== 32'h0) $display("FAIL async_rst_load: got %0h expected 0", v); else n_pass++;
    rd(A_COUNT, v);  n_total++; if (v !== 32'h0) $display("FAIL async_rst_count: got %0h expected 0", v); else n_pass++;
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL async_rst_status: got %0h expected 0", v); else n_pass++;
    step(2);
    @(negedge clk);
    reset_n = 1'b1;
    step(8);
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL post_rst_status: got %0h expected 0", v); else n_pass++;
    rd(A_CTRL, v);   n_total++; if (v !== 32'h0) $display("FAIL post_rst_ctrl: got %0h expected 0", v); else n_pass++;
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(A_LOAD, 32'h3);
    wr(A_CTRL, 32'h005);
    rd(A_COUNT, v); n_total++; if (v !== 32'h3) $display("FAIL os_count_start: got %0h expected 3", v); else n_pass++;
    for (int i = 2; i >= 0; i--) begin
      step(1);
      rd(A_COUNT, v);  n_total++; if (v !== 32'(i)) $display("FAIL os_count: got %0h expected %0h", v, i); else n_pass++;
      rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL os_status_early: got %0h expected 0", v); else n_pass++;
    end
    step(1);
    rd(A_STATUS, v); n_total++; if (v !== 32'h1) $display("FAIL os_expired: got %0h expected 1", v); else n_pass++;
    n_total++; if (bus.irq !== 1'b1) $display("FAIL os_irq: got %b expected 1", bus.irq); else n_pass++;
    rd(A_CTRL, v);   n_total++; if (v !== 32'h004) $display("FAIL os_ctrl_en_off: got %0h expected 4", v); else n_pass++;
    step(3);
    rd(A_COUNT, v);  n_total++; if (v !== 32'h0) $display("FAIL os_count_hold: got %0h expected 0", v); else n_pass++;
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_autoreload;
    logic [31:0] v;
    wr(A_LOAD, 32'h1);
    wr(A_CTRL, 32'h203);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      rd(A_STATUS, v);
      n_total++; if (v !== ((k >= 6) ? 32'h1 : 32'h0)) $display("FAIL ar_first_expiry k=%0d: got %0h expected %0h", k, v, (k >= 6) ? 1 : 0); else n_pass++;
    end
    n_total++; if (bus.irq !== 1'b0) $display("FAIL ar_irq_masked: got %b expected 0", bus.irq); else n_pass++;
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL ar_clear: got %0h expected 0", v); else n_pass++;
    step(4);
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL ar_no_early_expiry: got %0h expected 0", v); else n_pass++;
    step(1);
    rd(A_STATUS, v); n_total++; if (v !== 32'h1) $display("FAIL ar_second_expiry: got %0h expected 1", v); else n_pass++;
    wr(A_CTRL, 32'h207);
    n_total++; if (bus.irq !== 1'b1) $display("FAIL ar_irq_enabled: got %b expected 1", bus.irq); else n_pass++;
    rd(A_CTRL, v);  n_total++; if (v !== 32'h207) $display("FAIL ar_ctrl_readback: got %0h expected 207", v); else n_pass++;
    rd(A_COUNT, v); n_total++; if (v !== 32'h1) $display("FAIL ar_no_reload_on_ctrl: got %0h expected 1", v); else n_pass++;
    wr(A_LOAD, 32'h4);
    rd(A_COUNT, v); n_total++; if (v !== 32'h1) $display("FAIL ar_load_deferred: got %0h expected 1", v); else n_pass++;
    step(4);
    rd(A_COUNT, v); n_total++; if (v !== 32'h4) $display("FAIL ar_new_load_used: got %0h expected 4", v); else n_pass++;
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
  endtask

  task automatic test_collisions;
    logic [31:0] v;
    wr(A_LOAD, 32'h5);
    wr(A_CTRL, 32'h001);
    wr(A_COUNT, 32'h10);
    rd(A_COUNT, v); n_total++; if (v !== 32'h10) $display("FAIL col_count_write_wins: got %0h expected 10", v); else n_pass++;
    step(1);
    rd(A_COUNT, v); n_total++; if (v !== 32'hF) $display("FAIL col_count_resume: got %0h expected f", v); else n_pass++;
    step(15);
    rd(A_COUNT, v);  n_total++; if (v !== 32'h0) $display("FAIL col_count_zero: got %0h expected 0", v); else n_pass++;
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL col_not_yet_expired: got %0h expected 0", v); else n_pass++;
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v); n_total++; if (v !== 32'h1) $display("FAIL col_set_beats_clear: got %0h expected 1", v); else n_pass++;
    rd(A_CTRL, v);   n_total++; if (v !== 32'h0) $display("FAIL col_done_en: got %0h expected 0", v); else n_pass++;
    wr(A_STATUS, 32'h0);
    rd(A_STATUS, v); n_total++; if (v !== 32'h1) $display("FAIL col_write0_noeffect: got %0h expected 1", v); else n_pass++;
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, v); n_total++; if (v !== 32'h0) $display("FAIL col_clear: got %0h expected 0", v); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_bus;
    logic [31:0] v;
    wr(A_LOAD, 32'hA5);
    wr(A_COUNT, 32'h3C);
    bus.DataAdr = A_LOAD;  bus.WriteData = 32'hFFFF; step(1);
    bus.DataAdr = A_COUNT; step(1);
    bus.DataAdr = A_CTRL;  bus.WriteData = 32'h1; step(1);
    rd(A_LOAD, v);  n_total++; if (v !== 32'hA5) $display("FAIL bus_noWE_load: got %0h expected a5", v); else n_pass++;
    rd(A_COUNT, v); n_total++; if (v !== 32'h3C) $display("FAIL bus_noWE_count: got %0h expected 3c", v); else n_pass++;
    rd(A_CTRL, v);  n_total++; if (v !== 32'h0) $display("FAIL bus_noWE_ctrl: got %0h expected 0", v); else n_pass++;
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    rd(BASE + 32'h20, v); n_total++; if (v !== 32'h0) $display("FAIL bus_unmapped_read: got %0h expected 0", v); else n_pass++;
    rd(A_LOAD, v);  n_total++; if (v !== 32'hA5) $display("FAIL bus_unmapped_load: got %0h expected a5", v); else n_pass++;
    rd(A_COUNT, v); n_total++; if (v !== 32'h3C) $display("FAIL bus_unmapped_count: got %0h expected 3c", v); else n_pass++;
`ifndef TIMER_CAPTURE_EN
    wr(A_CAP, 32'h1234);
    rd(A_CAP, v);   n_total++; if (v !== 32'h0) $display("FAIL bus_cap_absent: got %0h expected 0", v); else n_pass++;
`endif
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture;
    logic [31:0] v;
    wr(A_COUNT, 32'h7);
    cap_in = 1'b1;
    step(3);
    rd(A_CAP, v); n_total++; if (v !== 32'h7) $display("FAIL cap_first: got %0h expected 7", v); else n_pass++;
    wr(A_COUNT, 32'h3);
    step(3);
    rd(A_CAP, v); n_total++; if (v !== 32'h7) $display("FAIL cap_held_high: got %0h expected 7", v); else n_pass++;
    cap_in = 1'b0;
    step(3);
    cap_in = 1'b1;
    step(3);
    rd(A_CAP, v); n_total++; if (v !== 32'h3) $display("FAIL cap_second: got %0h expected 3", v); else n_pass++;
    cap_in = 1'b0;
  endtask
`endif

  task automatic test_random;
    logic [31:0] v;
    logic [31:0] ctrl;
    logic [31:0] exp_cnt;
    logic        exp_en;
    logic        exp_exp;
    int          l, s, au, ie, p;
    for (int it = 0; it < 8; it++) begin
      l  = int'($urandom_range(0, 6));
      s  = int'($urandom_range(0, 3));
      au = int'($urandom_range(0, 1));
      ie = int'($urandom_range(0, 1));
      p  = (l + 1) * (s + 1);
      ctrl = {16'h0, 8'(s), 5'h00, 1'(ie), 1'(au), 1'b1};
      wr(A_CTRL, 32'h0);
      wr(A_STATUS, 32'h1);
      wr(A_LOAD, 32'(l));
      wr(A_CTRL, ctrl);
      rd(A_COUNT, v);
      n_total++; if (v !== 32'(l)) $display("FAIL rnd_start it=%0d: got %0h expected %0h", it, v, l); else n_pass++;
      for (int k = 1; k <= 2 * p + 2; k++) begin
        step(1);
        exp_exp = (k >= p);
        if (au == 0 && k >= p) begin
          exp_cnt = 32'h0;
          exp_en  = 1'b0;
        end else begin
          exp_cnt = 32'(l - (k % p) / (s + 1));
          exp_en  = 1'b1;
        end
        rd(A_COUNT, v);
        n_total++; if (v !== exp_cnt) $display("FAIL rnd_count it=%0d k=%0d: got %0h expected %0h", it, k, v, exp_cnt); else n_pass++;
        rd(A_STATUS, v);
        n_total++; if (v !== {31'h0, exp_exp}) $display("FAIL rnd_status it=%0d k=%0d: got %0h expected %0h", it, k, v, exp_exp); else n_pass++;
        n_total++; if (bus.irq !== (exp_exp & 1'(ie))) $display("FAIL rnd_irq it=%0d k=%0d: got %b expected %b", it, k, bus.irq, exp_exp & 1'(ie)); else n_pass++;
        rd(A_CTRL, v);
        n_total++; if (v !== {ctrl[31:1], exp_en}) $display("FAIL rnd_ctrl it=%0d k=%0d: got %0h expected %0h", it, k, v, {ctrl[31:1], exp_en}); else n_pass++;
      end
    end
  endtask

  initial begin
    bus.WEtimer   = 1'b0;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h0;
    #12;
    reset_n = 1'b1;
    step(1);
    test_reset();
    test_oneshot();
    test_autoreload();
    test_collisions();
    test_bus();
`ifdef TIMER_CAPTURE_EN
    test_capture();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
